// File: rtl/pkt_rr_arbiter.sv
// Packet-aware round-robin arbiter: four FWFT ingress FIFOs onto one registered
// valid/ready write path, holding the grant for a whole frame and truncating runaway frames.
module pkt_rr_arbiter #(
   parameter int DATA_WIDTH    = 64,
   parameter int MAX_PKT_WORDS = 256,
   parameter int CNT_WIDTH     = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            i_port_en,
   input  logic                  i_fifo1_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo1_data,
   input  logic                  i_fifo1_eop,
   input  logic                  i_fifo2_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo2_data,
   input  logic                  i_fifo2_eop,
   input  logic                  i_fifo3_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo3_data,
   input  logic                  i_fifo3_eop,
   input  logic                  i_fifo4_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo4_data,
   input  logic                  i_fifo4_eop,
   output logic                  o_fifo1_rd_en,
   output logic                  o_fifo2_rd_en,
   output logic                  o_fifo3_rd_en,
   output logic                  o_fifo4_rd_en,
   output logic [DATA_WIDTH-1:0] o_sdata,
   output logic                  o_sop,
   output logic                  o_eop,
   output logic                  o_data_valid,
   input  logic                  i_out_ready,
   output logic [3:0]            o_grant,
   output logic                  o_trunc
);

   typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

   state_t                 state;
   logic [1:0]             last_port;
   logic [1:0]             cur_port;
   logic [CNT_WIDTH-1:0]   word_cnt;
   logic                   sop_pending;

   logic [3:0]             empty_vec;
   logic [3:0]             eop_vec;
   logic [3:0]             cand;
   logic [3:0]             rd_vec;
   logic [DATA_WIDTH-1:0]  head_data;
   logic                   head_empty;
   logic                   head_eop;
   logic                   free;
   logic                   pop;
   logic                   last_word;
   logic                   pick_found;
   logic [1:0]             pick_port;
   logic [1:0]             scan_idx;

   assign empty_vec = {i_fifo4_empty, i_fifo3_empty, i_fifo2_empty, i_fifo1_empty};
   assign eop_vec   = {i_fifo4_eop, i_fifo3_eop, i_fifo2_eop, i_fifo1_eop};
   assign cand      = i_port_en & ~empty_vec;

   assign head_empty = empty_vec[cur_port];
   assign head_eop   = eop_vec[cur_port];

   always_comb begin
      head_data = i_fifo1_data;
      case (cur_port)
         2'd0: head_data = i_fifo1_data;
         2'd1: head_data = i_fifo2_data;
         2'd2: head_data = i_fifo3_data;
         2'd3: head_data = i_fifo4_data;
         default: head_data = i_fifo1_data;
      endcase
   end

   // The output slot can take a word when empty or being drained this cycle;
   // a frame being dropped drains regardless of the slot.
   assign free      = !o_data_valid || i_out_ready;
   assign pop       = !head_empty && ((state == XFER && free) || state == DROP);
   assign last_word = (word_cnt == CNT_WIDTH'(MAX_PKT_WORDS - 1));
   assign rd_vec    = pop ? (4'b0001 << cur_port) : 4'b0000;

   assign o_fifo1_rd_en = rd_vec[0];
   assign o_fifo2_rd_en = rd_vec[1];
   assign o_fifo3_rd_en = rd_vec[2];
   assign o_fifo4_rd_en = rd_vec[3];

   // Rotating search starting just after the last served port; the wrap of the
   // 2-bit index makes the last served port the lowest-priority candidate.
   always_comb begin
      pick_found = 1'b0;
      pick_port  = 2'd0;
      scan_idx   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         scan_idx = last_port + 2'(i);
         if (!pick_found && cand[scan_idx]) begin
            pick_found = 1'b1;
            pick_port  = scan_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_port    <= 2'd3;
         cur_port     <= 2'd0;
         word_cnt     <= '0;
         sop_pending  <= 1'b0;
         o_grant      <= 4'b0000;
         o_data_valid <= 1'b0;
         o_sdata      <= '0;
         o_sop        <= 1'b0;
         o_eop        <= 1'b0;
         o_trunc      <= 1'b0;
      end else begin
         o_trunc <= 1'b0;
         if (free) begin
            o_data_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state       <= XFER;
                  cur_port    <= pick_port;
                  o_grant     <= 4'b0001 << pick_port;
                  word_cnt    <= '0;
                  sop_pending <= 1'b1;
               end
            end
            XFER: begin
               if (pop) begin
                  o_data_valid <= 1'b1;
                  o_sdata      <= head_data;
                  o_sop        <= sop_pending;
                  sop_pending  <= 1'b0;
                  word_cnt     <= word_cnt + CNT_WIDTH'(1);
                  if (head_eop) begin
                     o_eop     <= 1'b1;
                     state     <= IDLE;
                     last_port <= cur_port;
                     o_grant   <= 4'b0000;
                  end else if (last_word) begin
                     // Runaway frame: close it here and discard the rest.
                     o_eop   <= 1'b1;
                     o_trunc <= 1'b1;
                     state   <= DROP;
                  end else begin
                     o_eop <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (pop && head_eop) begin
                  state     <= IDLE;
                  last_port <= cur_port;
                  o_grant   <= 4'b0000;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Bench for pkt_rr_arbiter: FIFO models feed the DUT, and a frame-level round-robin
// model predicts the exact output word stream, truncations included.
module tb_pkt_rr_arbiter;

   localparam int DW   = 64;
   localparam int MAXW = 8;
   localparam int CW   = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          eop;
      logic          first;
      logic [15:0]   idx;
   } fword_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic          trunc;
   } oword_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    port_en;
   logic          fe [4];
   logic [DW-1:0] fd [4];
   logic          feop [4];
   logic          rd1, rd2, rd3, rd4;
   logic [3:0]    rd_vec;
   logic [DW-1:0] sdata;
   logic          sop, eop, valid, out_ready, trunc;
   logic [3:0]    grant;

   fword_t fq [4][$];
   fword_t pend [4][$];
   oword_t exp_q [$];
   int     sop_offs [$];
   int     eop_offs [$];
   logic   force_empty [4];
   logic   stalled_prev;
   logic [3:0] rd_s;
   logic [3:0] grant_seen;
   int     bubble_pct, ready_mode, cyc, vectors, miscompares;
   int     trunc_seen, trunc_exp, model_last, first_valid, load_cyc;

   assign rd_vec = {rd4, rd3, rd2, rd1};

   always #5 clk = ~clk;

   pkt_rr_arbiter #(.DATA_WIDTH(DW), .MAX_PKT_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .i_port_en(port_en),
      .i_fifo1_empty(fe[0]), .i_fifo1_data(fd[0]), .i_fifo1_eop(feop[0]),
      .i_fifo2_empty(fe[1]), .i_fifo2_data(fd[1]), .i_fifo2_eop(feop[1]),
      .i_fifo3_empty(fe[2]), .i_fifo3_data(fd[2]), .i_fifo3_eop(feop[2]),
      .i_fifo4_empty(fe[3]), .i_fifo4_data(fd[3]), .i_fifo4_eop(feop[3]),
      .o_fifo1_rd_en(rd1), .o_fifo2_rd_en(rd2), .o_fifo3_rd_en(rd3), .o_fifo4_rd_en(rd4),
      .o_sdata(sdata), .o_sop(sop), .o_eop(eop), .o_data_valid(valid),
      .i_out_ready(out_ready), .o_grant(grant), .o_trunc(trunc)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Frame words carry port, frame number and word index so misrouting shows up in sdata.
   task automatic loadFrame(input int p, input int len, input int fid);
      fword_t w;
      for (int k = 0; k < len; k++) begin
         w.data  = {8'(p + 1), 8'(fid), 16'(k), 32'($urandom)};
         w.eop   = (k == len - 1);
         w.first = (k == 0);
         w.idx   = 16'(k);
         fq[p].push_back(w);
         pend[p].push_back(w);
      end
   endtask

   // Frame-level round robin over everything queued: whole frames in rotating port
   // order, each frame cut to MAXW words with the last kept word closing it.
   task automatic buildModel(input logic [3:0] en);
      bit     found;
      int     p, k;
      fword_t w;
      oword_t o;
      do begin
         found = 0;
         for (int i = 1; i <= 4 && !found; i++) begin
            p = (model_last + i) % 4;
            if (en[p] && pend[p].size() > 0) begin
               found      = 1;
               model_last = p;
               k          = 0;
               do begin
                  w = pend[p].pop_front();
                  if (k < MAXW) begin
                     o.data  = w.data;
                     o.sop   = (k == 0);
                     o.trunc = (k == MAXW - 1) && !w.eop;
                     o.eop   = w.eop || o.trunc;
                     exp_q.push_back(o);
                     if (o.trunc) trunc_exp++;
                  end
                  k++;
               end while (!w.eop);
            end
         end
      end while (found);
   endtask

   task automatic driveInputs();
      for (int p = 0; p < 4; p++) begin
         if (fq[p].size() == 0) begin
            fe[p]   = 1'b1;
            fd[p]   = '0;
            feop[p] = 1'b0;
         end else begin
            fd[p]   = fq[p][0].data;
            feop[p] = fq[p][0].eop;
            fe[p]   = force_empty[p] ||
                      (!fq[p][0].first && int'($urandom_range(99)) < bubble_pct);
         end
      end
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc % 3 == 0);
         default: out_ready = ($urandom_range(99) < 75);
      endcase
   endtask

   task automatic sampleOutputs();
      bit free;
      rd_s = rd_vec;
      free = !valid || out_ready;
      grant_seen = grant_seen | grant;
      if (rd_s != 4'b0000) begin
         checkOutput("rd_onehot", 64'($countones(rd_s)), 64'd1);
         for (int p = 0; p < 4; p++) begin
            if (rd_s[p]) begin
               checkOutput("rd_empty", 64'(fe[p]), 64'd0);
               checkOutput("rd_grant", 64'(grant), 64'(4'b0001 << p));
               if (!free && fq[p].size() > 0)
                  checkOutput("rd_unfree", 64'(fq[p][0].idx >= 16'(MAXW)), 64'd1);
            end
         end
      end
      if (stalled_prev) checkOutput("hold_valid", 64'(valid), 64'd1);
      if (trunc) begin
         trunc_seen++;
         checkOutput("trunc_word", 64'(valid && exp_q.size() > 0 && exp_q[0].trunc), 64'd1);
      end
      if (valid) begin
         if (first_valid < 0) first_valid = cyc;
         if (exp_q.size() == 0) begin
            checkOutput("extra_word", 64'd1, 64'd0);
         end else begin
            checkOutput("sdata", sdata, exp_q[0].data);
            checkOutput("sop", 64'(sop), 64'(exp_q[0].sop));
            checkOutput("eop", 64'(eop), 64'(exp_q[0].eop));
            if (out_ready) begin
               if (sop) sop_offs.push_back(cyc - first_valid);
               if (eop) eop_offs.push_back(cyc - first_valid);
               void'(exp_q.pop_front());
            end
         end
      end
      stalled_prev = valid && !out_ready;
   endtask

   // One clock: sample away from the edge, retire popped FIFO words, redrive.
   task automatic applyStimulus();
      @(negedge clk);
      #1;
      sampleOutputs();
      @(posedge clk);
      cyc++;
      for (int p = 0; p < 4; p++)
         if (rd_s[p] && fq[p].size() > 0) void'(fq[p].pop_front());
      #1;
      driveInputs();
   endtask

   function automatic bit drained();
      if (exp_q.size() != 0) return 0;
      for (int p = 0; p < 4; p++)
         if (port_en[p] && fq[p].size() != 0) return 0;
      return 1;
   endfunction

   task automatic runUntilDrained(input int budget);
      int n = 0;
      while (!drained() && n < budget) begin
         applyStimulus();
         n++;
      end
      checkOutput("drain_timeout", 64'(drained()), 64'd1);
      repeat (3) applyStimulus();
      checkOutput("exp_left", 64'(exp_q.size()), 64'd0);
      checkOutput("trunc_count", 64'(trunc_seen), 64'(trunc_exp));
      checkOutput("idle_grant", 64'(grant), 64'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      for (int p = 0; p < 4; p++) begin
         fq[p].delete();
         pend[p].delete();
         force_empty[p] = 1'b0;
      end
      exp_q.delete();
      model_last   = 3;
      stalled_prev = 1'b0;
      trunc_seen   = 0;
      trunc_exp    = 0;
      grant_seen   = 4'b0000;
      driveInputs();
      repeat (2) applyStimulus();
      checkOutput("rst_ctrl", 64'({valid, sop, eop, trunc, grant, rd_vec}), 64'd0);
      checkOutput("rst_sdata", sdata, 64'd0);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n, nf, len;
      vectors = 0; miscompares = 0; cyc = 0; first_valid = -1; load_cyc = 0;
      port_en = 4'hF; ready_mode = 0; bubble_pct = 0; out_ready = 1'b1;

      // Four 3-word frames arriving together: port order, one bubble, 2-cycle latency.
      doReset();
      repeat (2) applyStimulus();
      first_valid = -1;
      sop_offs.delete();
      eop_offs.delete();
      for (int p = 0; p < 4; p++) loadFrame(p, 3, p);
      buildModel(port_en);
      driveInputs();
      load_cyc = cyc;
      runUntilDrained(200);
      checkOutput("first_latency", 64'(first_valid - load_cyc), 64'd2);
      checkOutput("sop_count", 64'(sop_offs.size()), 64'd4);
      checkOutput("eop_count", 64'(eop_offs.size()), 64'd4);
      for (int i = 0; i < 4 && i < sop_offs.size() && i < eop_offs.size(); i++) begin
         checkOutput("sop_slot", 64'(sop_offs[i]), 64'(4 * i));
         checkOutput("eop_slot", 64'(eop_offs[i]), 64'(4 * i + 2));
      end

      // Ports 2 and 4 alternate; then a disabled port must never be granted.
      doReset();
      loadFrame(1, 3, 0); loadFrame(1, 2, 1);
      loadFrame(3, 4, 0); loadFrame(3, 2, 1);
      buildModel(port_en);
      driveInputs();
      runUntilDrained(300);
      checkOutput("unloaded_grant", 64'(grant_seen & 4'b0101), 64'd0);
      port_en = 4'b0111;
      loadFrame(3, 3, 9);
      buildModel(port_en);
      driveInputs();
      repeat (20) begin
         applyStimulus();
         checkOutput("dis_grant", 64'(grant), 64'd0);
      end

      // Back-pressure pattern 1,0,0 on a 5-word frame.
      port_en = 4'hF;
      doReset();
      ready_mode = 1;
      loadFrame(0, 5, 0);
      buildModel(port_en);
      driveInputs();
      runUntilDrained(200);

      // Port 1 starves mid-frame; grant must stay put while port 2 waits.
      ready_mode = 0;
      doReset();
      loadFrame(0, 5, 0);
      loadFrame(1, 3, 0);
      buildModel(port_en);
      driveInputs();
      n = 0;
      while (fq[0].size() > 3 && n < 50) begin
         applyStimulus();
         n++;
      end
      checkOutput("stall_reached", 64'(fq[0].size()), 64'd3);
      force_empty[0] = 1'b1;
      driveInputs();
      repeat (4) begin
         applyStimulus();
         checkOutput("held_grant", 64'(grant), 64'd1);
      end
      force_empty[0] = 1'b0;
      driveInputs();
      runUntilDrained(200);

      // Exactly MAXW words passes; MAXW+3 is truncated and the next frame survives.
      doReset();
      loadFrame(0, MAXW, 0);
      loadFrame(2, MAXW + 3, 0);
      loadFrame(2, 2, 1);
      buildModel(port_en);
      driveInputs();
      runUntilDrained(300);
      checkOutput("trunc_total", 64'(trunc_exp), 64'd1);

      // Asynchronous reset in the middle of a frame.
      doReset();
      loadFrame(1, 6, 1);
      buildModel(port_en);
      driveInputs();
      n = 0;
      while (exp_q.size() > 4 && n < 50) begin
         applyStimulus();
         n++;
      end
      checkOutput("mid_reached", 64'(exp_q.size() <= 4 && valid), 64'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_ctrl", 64'({valid, sop, eop, trunc, grant, rd_vec}), 64'd0);
      checkOutput("async_sdata", sdata, 64'd0);
      doReset();
      for (int p = 0; p < 4; p++) loadFrame(p, 3, 5);
      buildModel(port_en);
      driveInputs();
      runUntilDrained(200);

      // Randomized rounds: enables, frame counts/lengths, FIFO bubbles and ready.
      for (int r = 0; r < 8; r++) begin
         doReset();
         port_en    = (r == 0) ? 4'h0 : 4'($urandom_range(15));
         ready_mode = 2;
         bubble_pct = 25;
         for (int p = 0; p < 4; p++) begin
            nf = int'($urandom_range(3));
            for (int f = 0; f < nf; f++) begin
               len = ($urandom_range(4) == 0) ? MAXW : int'($urandom_range(12, 1));
               loadFrame(p, len, f);
            end
         end
         buildModel(port_en);
         driveInputs();
         runUntilDrained(3000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
